// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for RV32M
// (DIV, DIVU, REM, REMU). Divide-by-zero and signed overflow finish one
// cycle after the accepting edge; every other operation spends exactly
// XLEN cycles in CALC before a one-cycle DONE.
//
// Handshake: an operation is accepted on a rising edge where the unit is
// IDLE, start=1 and flush=0. busy is high in CALC and DONE. done is high
// only in DONE, and result is valid in that same cycle. result then holds
// its value until a later operation completes. start is ignored while busy.
// flush sends the unit back to IDLE on the next edge, leaves result
// unchanged, and prevents the aborted operation from ever raising done.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             op_rem_q, op_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  result_q, result_d;

  // Operand decode on the raw inputs; only used on the accepting edge.
  logic            in_signed;
  logic            in_rem;
  logic            in_div_zero;
  logic            in_ovf;
  logic [XLEN-1:0] in_special;
  logic [XLEN-1:0] abs_dvd;
  logic [XLEN-1:0] abs_dvs;

  // Decode the incoming operation, pick the early special result and form magnitudes.
  always_comb begin
    in_signed   = ~div_op[0];
    in_rem      = div_op[1];
    in_div_zero = (divisor == '0);
    in_ovf      = in_signed && (dividend == MIN_NEG) && (divisor == '1);
    in_special  = '0;
    if (in_div_zero) begin
      in_special = in_rem ? dividend : '1;
    end else if (in_ovf) begin
      in_special = in_rem ? '0 : MIN_NEG;
    end
    abs_dvd = (in_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    abs_dvs = (in_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
  end

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in XLEN+1 bits and bit XLEN of the trial
  // difference is a reliable "went negative" flag.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;
  logic [XLEN-1:0] fin_res;

  // Compute the next partial remainder/quotient and the sign-corrected final value.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    rem_nx  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ~trial[XLEN]};
    fin_quo = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
    fin_rem = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    fin_res = op_rem_q ? fin_rem : fin_quo;
  end

  // Next-state logic: sequencing of IDLE/CALC/DONE and working register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_rem_d = in_rem;
          if (in_div_zero || in_ovf) begin
            result_d = in_special;
            state_d  = S_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = abs_dvd;
            dvs_d     = abs_dvs;
            neg_quo_d = in_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_rem_d = in_signed && dividend[XLEN-1];
            cnt_d     = CNT_LAST;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == '0) begin
          // Final iteration: register the finished, sign-corrected result.
          result_d = fin_res;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An aborted operation never publishes a result.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: arithmetic results, latency, busy window,
// early special cases, flush abort, ignored re-start and mid-run reset.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_exp;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .div_op   (div_op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one operation and follow it. lat counts edges from the accepting
  // edge (inclusive) to the cycle where done is seen. flush_at>0 raises
  // flush during that cycle; repulse re-drives start at cycles 5 and 20.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit repulse,
                        output int lat, output bit got_done, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; div_op = op; dividend = a; divisor = b;
    @(posedge clk);
    lat = 999; got_done = 1'b0; res = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start    = 1'b0;
      flush    = 1'b0;
      div_op   = 2'($urandom_range(0, 3));
      dividend = $urandom;
      divisor  = $urandom;
      if (done) begin
        got_done = 1'b1; res = result; lat = k;
        break;
      end
      if (flush_at > 0 && k == flush_at + 1) begin
        lat = k;
        break;
      end
      if (k == flush_at) flush = 1'b1;
      if (repulse && (k == 5 || k == 20)) start = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat; bit gd; logic [31:0] res;
    run_op(op, a, b, 0, 1'b0, lat, gd, res);
    check({tag, " done"}, {31'b0, gd}, 32'd1);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_in_done"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, " idle_after"}, {30'b0, busy, done}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int lat; bit gd; logic [31:0] res;
    // Reset
    rst = 1'b1; start = 1'b0; flush = 1'b0; div_op = '0; dividend = '0; divisor = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outs", {28'b0, state_dbg, busy, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    // Normal operations
    do_op("div -7/2",      OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem -7/2",      OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu max/1",    OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    do_op("remu 100/7",    OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    do_op("divu 5/9",      OP_DIVU, 32'd5, 32'd9, 32'd0, 33);
    do_op("div 100/-7",    OP_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    do_op("rem 100/-7",    OP_REM,  32'd100, 32'hFFFF_FFF9, 32'd2, 33);
    do_op("rem -100/7",    OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    do_op("divu min/3",    OP_DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33);
    do_op("remu min/3",    OP_REMU, 32'h8000_0000, 32'd3, 32'd2, 33);
    do_op("div min/2",     OP_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 33);
    do_op("divu min/-1",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // Divide by zero and signed overflow resolve early
    do_op("div by0",       OP_DIV,  32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("divu by0",      OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem by0",       OP_REM,  32'd1234, 32'd0, 32'd1234, 1);
    do_op("remu by0",      OP_REMU, 32'd1234, 32'd0, 32'd1234, 1);
    do_op("div ovf",       OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem ovf",       OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush at cycle 10 of a running DIV: no done, result keeps prior value
    run_op(OP_DIV, 32'd5000, 32'd7, 10, 1'b0, lat, gd, res);
    check("flush no_done", {31'b0, gd}, 32'd0);
    check("flush outs", {30'b0, busy, done}, 32'd0);
    check("flush result_held", result, last_exp);
    do_op("after flush div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

    // start re-pulsed during CALC is ignored
    run_op(OP_DIV, 32'd1000, 32'hFFFF_FFF6, 0, 1'b1, lat, gd, res);
    check("repulse done", {31'b0, gd}, 32'd1);
    check("repulse result", res, 32'hFFFF_FF9C);
    check("repulse latency", 32'(lat), 32'd33);
    @(negedge clk);
    check("repulse idle_after", {30'b0, busy, done}, 32'd0);

    // Reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; div_op = OP_DIVU; dividend = 32'd999; divisor = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midcalc busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midcalc reset outs", {28'b0, state_dbg, busy, done}, 32'd0);
    check("midcalc reset result", result, 32'd0);
    do_op("after reset divu", OP_DIVU, 32'd999, 32'd4, 32'd249, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider completing the RV32M extension alongside the single-cycle ALU; executes DIV, DIVU, REM, REMU.
- Sits in the EX stage. The pipeline issues an operation with a start pulse and stalls while busy is high. The result is captured when done pulses.
- Radix-2 restoring algorithm, one quotient bit per cycle. Spec-defined RISC-V corner cases (divide-by-zero, signed overflow) resolve early.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  issue request; sampled only in IDLE
- flush  in  1  pipeline flush; aborts any in-flight operation
- div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  XLEN  rs1 value; sampled with start
- divisor  in  XLEN  rs2 value; sampled with start
- busy  out  1  high in CALC and DONE states
- done  out  1  one-cycle pulse; result valid in the same cycle
- result  out  XLEN  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0. Reset wins over start and flush in the same cycle.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch div_op and operands.
  - divisor==0 or (DIV/REM with dividend==32'h8000_0000 and divisor==32'hFFFF_FFFF): compute the special result and go to DONE.
  - Otherwise load the working registers and go to CALC with counter=XLEN-1.
- CALC operand preparation, signed ops (DIV/REM):
  - Take the absolute values of both operands.
  - quotient negate flag = dividend[31]^divisor[31].
  - remainder negate flag = dividend[31].
- CALC operand preparation, unsigned ops: operands used as-is; both negate flags 0.
- CALC iteration, per cycle:
  - {rem,quo} shifts left by 1.
  - trial = rem_shifted - divisor_abs, computed at XLEN+1 bits.
  - If trial is non-negative: rem=trial, quo[0]=1; else quo[0]=0.
  - Counter decrements. When counter==0, that iteration is the last and the state goes to DONE.
  - Exactly XLEN cycles are spent in CALC.
- DONE: done=1 and result is driven for one cycle.
  - Quotient ops: result = quotient, two's-complement negated if the quotient negate flag is set.
  - Remainder ops: result = remainder, negated if the remainder negate flag is set.
  - Next state: IDLE.
- Special results:
  - Divide by zero: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = dividend.
  - Signed overflow: DIV = 32'h8000_0000; REM = 0.
- Latency from the start edge to the done cycle:
  - Normal operations: XLEN+1 = 33 cycles.
  - Special cases: 1 cycle.
- Throughput: the next start is accepted in the cycle after done, back in IDLE.
- start while busy=1: ignored. No queueing, no error.
- flush=1 in any state: state goes to IDLE next cycle, busy=0, done=0, result unchanged. No done pulse occurs for an aborted operation.
  - flush together with start in IDLE: start is ignored.
- Inputs may change freely after the accepting edge; only latched copies are used.
- result is registered; done is asserted only in the DONE state.

Test Plan:
- DIV dividend=32'hFFFF_FFF9 (-7), divisor=2 -> done 33 cycles after start, result=32'hFFFF_FFFD (-3); REM with the same operands -> 32'hFFFF_FFFF (-1).
- DIVU 32'hFFFF_FFFF/1 -> 32'hFFFF_FFFF; REMU 100/7 -> 2; DIVU 5/9 -> 0, each after 33 cycles.
- Divide-by-zero, dividend=1234: DIV and DIVU -> 32'hFFFF_FFFF, REM and REMU -> 1234; done 1 cycle after start, busy high for exactly 1 cycle.
- Overflow 32'h8000_0000 / 32'hFFFF_FFFF: DIV -> 32'h8000_0000, REM -> 0, each with 1-cycle latency.
- Start a normal DIV, assert flush at cycle 10 -> busy=0 next cycle, no done pulse, result keeps its prior value; a new start next cycle completes normally.
- start re-pulsed with different operands at cycles 5 and 20 of a running DIV -> ignored, original result returned at cycle 33. rst asserted mid-CALC -> all outputs 0 on the next edge.
